// File: rtl/pwm_env_sm.sv
// Per-channel LED brightness envelopes (ramp up, hold, ramp down) stepped by a
// shared prescaler tick, driving duty values into downstream PWM comparators.
module pwm_env_sm #(
    parameter int NCH    = 8,
    parameter int W      = 5,
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [NCH-1:0]    trigger,
    input  logic [W-1:0]      peak,
    input  logic [HOLD_W-1:0] hold,
    input  logic              retrig,
    input  logic              loop,
    output logic [NCH*W-1:0]  pwm,
    output logic [NCH-1:0]    busy,
    output logic [NCH-1:0]    done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        HOLD = 2'd2,
        DOWN = 2'd3
    } state_e;

    // Loads during reset too, so a trigger held through reset is not an edge.
    logic [NCH-1:0] prev_q;

    always_ff @(posedge clk) begin
        prev_q <= trigger;
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        state_e            st_q, st_d;
        logic [W-1:0]      val_q, val_d;
        logic [W-1:0]      pk_q, pk_d;
        logic [HOLD_W-1:0] hl_q, hl_d;
        logic [HOLD_W-1:0] hc_q, hc_d;
        logic              dn_q, dn_d;
        logic              edg;
        logic              start;

        assign edg   = trigger[i] & ~prev_q[i];
        assign start = edg & ((st_q == IDLE) | retrig);

        always_comb begin
            st_d  = st_q;
            val_d = val_q;
            pk_d  = pk_q;
            hl_d  = hl_q;
            hc_d  = hc_q;
            dn_d  = 1'b0;
            if (start) begin
                st_d  = UP;
                val_d = '0;
                pk_d  = peak;
                hl_d  = hold;
                hc_d  = '0;
            end else begin
                case (st_q)
                    IDLE: ;
                    UP: begin
                        if (tick) begin
                            if (val_q == pk_q) begin
                                st_d = HOLD;
                                hc_d = '0;
                            end else begin
                                val_d = val_q + W'(1);
                                if (val_d == pk_q) begin
                                    st_d = HOLD;
                                    hc_d = '0;
                                end
                            end
                        end
                    end
                    HOLD: begin
                        if (tick) begin
                            if (hc_q == hl_q) st_d = DOWN;
                            else              hc_d = hc_q + HOLD_W'(1);
                        end
                    end
                    DOWN: begin
                        if (tick) begin
                            if (val_q != '0) val_d = val_q - W'(1);
                            // Reaching zero ends the envelope; loop re-arms it.
                            if (val_q == '0 || val_q == W'(1)) begin
                                if (loop && trigger[i]) begin
                                    st_d  = UP;
                                    val_d = '0;
                                    pk_d  = peak;
                                    hl_d  = hold;
                                    hc_d  = '0;
                                end else begin
                                    st_d = IDLE;
                                    dn_d = 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        st_d  = IDLE;
                        val_d = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                st_q  <= IDLE;
                val_q <= '0;
                pk_q  <= '0;
                hl_q  <= '0;
                hc_q  <= '0;
                dn_q  <= 1'b0;
            end else begin
                st_q  <= st_d;
                val_q <= val_d;
                pk_q  <= pk_d;
                hl_q  <= hl_d;
                hc_q  <= hc_d;
                dn_q  <= dn_d;
            end
        end

        assign pwm[i*W +: W] = val_q;
        assign busy[i]       = (st_q != IDLE);
        assign done[i]       = dn_q;
    end

endmodule

// File: tb/tb_pwm_env_sm.sv
// Scoreboard bench for pwm_env_sm: expected bus values are queued as
// stimulus is applied and compared once the clock edge has produced them.
module tb_pwm_env_sm;

    localparam int NCH = 8;
    localparam int W   = 5;
    localparam int HW  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             tick;
    logic [NCH-1:0]   trigger;
    logic [W-1:0]     peak;
    logic [HW-1:0]    hold;
    logic             retrig;
    logic             loop;
    logic [NCH*W-1:0] pwm;
    logic [NCH-1:0]   busy;
    logic [NCH-1:0]   done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [NCH*W-1:0] p;
        logic [NCH-1:0]   b;
        logic [NCH-1:0]   d;
        string            tag;
    } exp_t;

    exp_t sbq[$];
    exp_t e;

    pwm_env_sm #(.NCH(NCH), .W(W), .HOLD_W(HW)) dut (
        .clk(clk), .rst(rst), .tick(tick), .trigger(trigger),
        .peak(peak), .hold(hold), .retrig(retrig), .loop(loop),
        .pwm(pwm), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(string tag, int ch, int v, bit b, bit d);
        exp_t x;
        x.p = '0;
        x.b = '0;
        x.d = '0;
        x.p[ch*W +: W] = W'(v);
        x.b[ch] = b;
        x.d[ch] = d;
        x.tag = tag;
        sbq.push_back(x);
    endtask

    task automatic test_reset();
        rst = 1'b1; tick = 1'b1; trigger = '0; peak = 5'd9;
        hold = 4'd2; retrig = 1'b0; loop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) rst = 1'b0;
            tick = 1'b0;
            push1("reset", 0, 0, 0, 0);
            step();
            e = sbq.pop_front();
            checks++;
            if ({pwm, busy, done} !== {e.p, e.b, e.d}) begin
                failures++;
                $display("FAIL %s k=%0d: pwm=%h busy=%b done=%b want pwm=%h busy=%b done=%b",
                         e.tag, k, pwm, busy, done, e.p, e.b, e.d);
            end
        end
    endtask

    task automatic test_basic();
        int v[10] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, 0};
        peak = 5'd3; hold = 4'd1; tick = 1'b1;
        for (int k = 0; k < 10; k++) begin
            trigger[0] = 1'b1;
            push1("basic", 0, v[k], k < 8, k == 8);
            step();
            e = sbq.pop_front();
            checks++;
            if ({pwm, busy, done} !== {e.p, e.b, e.d}) begin
                failures++;
                $display("FAIL %s k=%0d: pwm=%h busy=%b done=%b want pwm=%h busy=%b done=%b",
                         e.tag, k, pwm, busy, done, e.p, e.b, e.d);
            end
        end
        trigger = '0;
        step();
    endtask

    task automatic test_zero_peak();
        peak = 5'd0; hold = 4'd0; tick = 1'b1;
        for (int k = 0; k < 6; k++) begin
            trigger[2] = 1'b1;
            push1("zero_peak", 2, 0, k < 3, k == 3);
            step();
            e = sbq.pop_front();
            checks++;
            if ({pwm, busy, done} !== {e.p, e.b, e.d}) begin
                failures++;
                $display("FAIL %s k=%0d: pwm=%h busy=%b done=%b want pwm=%h busy=%b done=%b",
                         e.tag, k, pwm, busy, done, e.p, e.b, e.d);
            end
        end
        trigger = '0;
        step();
    endtask

    task automatic test_retrig();
        int v[21] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 5,
                      6, 7, 7, 6, 5, 4, 3, 2, 1, 0};
        peak = 5'd7; hold = 4'd0; tick = 1'b1;
        for (int k = 0; k < 21; k++) begin
            trigger[1] = (k == 0) || (k == 5) || (k >= 10);
            retrig = (k < 10);
            push1("retrig", 1, v[k], k < 20, k == 20);
            step();
            e = sbq.pop_front();
            checks++;
            if ({pwm, busy, done} !== {e.p, e.b, e.d}) begin
                failures++;
                $display("FAIL %s k=%0d: pwm=%h busy=%b done=%b want pwm=%h busy=%b done=%b",
                         e.tag, k, pwm, busy, done, e.p, e.b, e.d);
            end
        end
        trigger = '0; retrig = 1'b0;
        step();
    endtask

    task automatic test_loop();
        int v[16] = '{0, 1, 2, 2, 1, 0, 1, 2, 2, 1, 0, 1, 2, 2, 1, 0};
        peak = 5'd2; hold = 4'd0; tick = 1'b1; loop = 1'b1;
        for (int k = 0; k < 16; k++) begin
            trigger[3] = (k <= 10);
            push1("loop", 3, v[k], k < 15, k == 15);
            step();
            e = sbq.pop_front();
            checks++;
            if ({pwm, busy, done} !== {e.p, e.b, e.d}) begin
                failures++;
                $display("FAIL %s k=%0d: pwm=%h busy=%b done=%b want pwm=%h busy=%b done=%b",
                         e.tag, k, pwm, busy, done, e.p, e.b, e.d);
            end
        end
        loop = 1'b0; trigger = '0;
        step();
    endtask

    task automatic test_stagger();
        int  n[NCH];
        bit  st[NCH];
        int  lenv;
        int  vv;
        exp_t x;
        lenv = 63;
        peak = 5'd31; hold = 4'd0;
        for (int c = 0; c < NCH; c++) begin
            n[c] = 0;
            st[c] = 0;
        end
        for (int k = 0; k < 290; k++) begin
            tick = (k % 4 == 0);
            if (k == 40) begin
                peak = 5'd5;
                hold = 4'd7;
            end
            x.p = '0; x.b = '0; x.d = '0; x.tag = "stagger";
            for (int c = 0; c < NCH; c++) begin
                if (k == 3 * c + 1) begin
                    trigger[c] = 1'b1;
                    st[c] = 1;
                    n[c] = 0;
                end else if (st[c] && tick && n[c] < lenv) begin
                    n[c]++;
                    x.d[c] = (n[c] == lenv);
                end
                if (!st[c])        vv = 0;
                else if (n[c] <= 31) vv = n[c];
                else if (n[c] <= 32) vv = 31;
                else               vv = 63 - n[c];
                x.p[c*W +: W] = W'(vv);
                x.b[c] = st[c] && (n[c] < lenv);
            end
            sbq.push_back(x);
            step();
            e = sbq.pop_front();
            checks++;
            if ({pwm, busy, done} !== {e.p, e.b, e.d}) begin
                failures++;
                $display("FAIL %s k=%0d: pwm=%h busy=%b done=%b want pwm=%h busy=%b done=%b",
                         e.tag, k, pwm, busy, done, e.p, e.b, e.d);
            end
        end
        tick = 1'b0; trigger = '0;
        step();
    endtask

    task automatic test_rst_mid();
        int v[13] = '{0, 0, 0, 0, 0, 0, 1, 2, 2, 2, 0, 0, 0};
        tick = 1'b1; peak = 5'd2; hold = 4'd3;
        for (int k = 0; k < 13; k++) begin
            rst = (k < 2) || (k == 10);
            trigger[5] = (k != 4);
            push1("rst_mid", 5, v[k], (k >= 5) && (k <= 9), 0);
            step();
            e = sbq.pop_front();
            checks++;
            if ({pwm, busy, done} !== {e.p, e.b, e.d}) begin
                failures++;
                $display("FAIL %s k=%0d: pwm=%h busy=%b done=%b want pwm=%h busy=%b done=%b",
                         e.tag, k, pwm, busy, done, e.p, e.b, e.d);
            end
        end
        rst = 1'b0; trigger = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_peak();
        test_retrig();
        test_loop();
        test_stagger();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_env_sm.md
Name: pwm_env_sm

Overview:
Multi-channel, parametrised successor to the single-channel LED fade state machine in the knight_rider front-panel blocks. Each channel runs an independent brightness envelope: ramp up to a programmable peak, hold, then ramp down. Each ramp step is gated by a shared prescaler tick. The block drives per-channel duty values into the downstream PWM comparators. It adds programmable peak, hold time, retrigger and loop modes, and done/busy status.

Parameters:
NCH, 8, number of independent channels
W, 5, width of each channel's duty value
HOLD_W, 4, width of hold-time counter/input

Ports:
clk  input  1  system clock
rst  input  1  reset
tick  input  1  one-cycle step strobe from shared prescaler
trigger  input  NCH  per-channel start request; rising edge is the event
peak  input  W  target duty, shared; latched per channel at start
hold  input  HOLD_W  extra ticks spent at peak, shared; latched per channel at start
retrig  input  1  1: edge while busy restarts channel; 0: edge while busy ignored
loop  input  1  1: channel restarts from 0 at end of DOWN if its trigger is still high
pwm  output  NCH*W  flattened duty values; channel i at bits [i*W +: W]
busy  output  NCH  channel state != IDLE
done  output  NCH  one-cycle pulse when a channel returns to IDLE from DOWN

Behaviour:
- Reset rst, synchronous, active-high; clock clk. rst has priority over all other inputs.
- During rst: every state=IDLE, pwm=0, busy=0, done=0, latched peak/hold=0, hold counter=0.
- During rst, the edge-detect register loads the current trigger value. A trigger held high through reset release is not an edge.
- Edge detect per channel: edge = trigger[i] & ~prev[i]. prev updates every cycle.
- Per-channel states: IDLE, UP, HOLD, DOWN. Channels are fully independent; no shared arbitration.
- Start, on edge in IDLE, or on edge in any state with retrig=1:
  - next cycle: state=UP, val=0, pk_lat=peak, hold_lat=hold, hcnt=0.
  - A tick in the same cycle as a start edge is ignored for that channel.
- Edge while busy with retrig=0: ignored, no state change.
- UP, on tick:
  - if val==pk_lat (only possible when pk_lat=0): go to HOLD, hcnt=0.
  - else val=val+1; if val+1==pk_lat, go to HOLD, hcnt=0.
- HOLD, on tick: if hcnt==hold_lat, go to DOWN; else hcnt=hcnt+1. HOLD lasts hold_lat+1 ticks.
- DOWN, on tick:
  - if val==0: end.
  - else val=val-1; if val==1: end.
- End of DOWN:
  - if loop=1 and trigger[i]=1: state=UP, val=0, pk_lat/hold_lat relatched, no done pulse.
  - otherwise state=IDLE and done[i]=1 for exactly one cycle, registered together with the IDLE transition.
- No tick means no change in UP/HOLD/DOWN.
- Envelope length with pk_lat=P>0: 2P+hold_lat+1 ticks. With P=0: hold_lat+3 ticks.
- Arithmetic is unsigned W-bit. val never exceeds pk_lat and never wraps below 0. P=2^W-1 is legal.
- Changes to peak/hold mid-envelope have no effect until the next start.
- pwm[i]=val, registered. busy is registered, so it is high from the cycle after the start edge.
- Illegal state encodings recover to IDLE on the next cycle with val=0.
- rst asserted mid-envelope forces IDLE/0 on the next edge regardless of tick or trigger.

Test Plan:
- peak=3, hold=1, tick=1 constant, edge ch0 → pwm[0] after successive clocks: 0,1,2,3,3,3,2,1,0; done[0] high only on the final cycle; busy[0] high cycles 1–8.
- peak=0, hold=0, tick=1, edge ch2 → pwm stays 0, IDLE after 3 ticks, single done pulse.
- retrig=1, edge ch1 again while pwm=4 in UP (peak=7) → pwm=0 next cycle, ramp restarts; with retrig=0 the same edge leaves the ramp unchanged.
- loop=1, trigger ch3 held high, peak=2, hold=0 → repeating 0,1,2,2,1,0,1,2,… with no done pulses; drop trigger → ends at 0 with one done.
- tick every 4th cycle, 8 channels triggered on staggered cycles, peak=31 → each channel independent, max 31, no wrap; peak changed mid-run does not affect running channels.
- trigger high during and after rst → no start; rst asserted mid-HOLD → pwm=0, busy=0 next cycle.
